// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state and
// instruction-class encodings, opcode map, ALU/operand-source codes and
// fault codes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU   = 3'd0,
        CL_LD    = 3'd1,
        CL_ST    = 3'd2,
        CL_BR_EQ = 3'd3,
        CL_BR_NE = 3'd4,
        CL_JMP   = 3'd5,
        CL_IMM   = 3'd6,
        CL_ILL   = 3'd7
    } iclass_t;

    // Opcode map (IR[6:0])
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0000111;
    localparam logic [6:0] OP_ADD = 7'b0001011;
    localparam logic [6:0] OP_SUB = 7'b0001111;
    localparam logic [6:0] OP_INV = 7'b0010011;
    localparam logic [6:0] OP_LSL = 7'b0010111;
    localparam logic [6:0] OP_LSR = 7'b0011011;
    localparam logic [6:0] OP_AND = 7'b0011111;
    localparam logic [6:0] OP_OR  = 7'b0100011;
    localparam logic [6:0] OP_SLT = 7'b0100111;
    localparam logic [6:0] OP_BEQ = 7'b0101111;
    localparam logic [6:0] OP_BNE = 7'b0110011;
    localparam logic [6:0] OP_JMP = 7'b0110111;
    localparam logic [6:0] OP_LUI = 7'b0111011;
    localparam logic [6:0] OP_LLI = 7'b0111111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_INV = 4'b0010;
    localparam logic [3:0] ALU_LSL = 4'b0011;
    localparam logic [3:0] ALU_LSR = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_LLI = 4'b1001;

    // ALU second-operand source
    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_OFF = 2'b01;
    localparam logic [1:0] SRC_IMM = 2'b10;

    // Fault codes
    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    // Instructions that finish in EXEC by redirecting (or not) the PC
    function automatic logic is_ctrl_xfer(input iclass_t c);
        return (c == CL_BR_EQ) || (c == CL_BR_NE) || (c == CL_JMP);
    endfunction

    // Instructions that end with a register-file write
    function automatic logic needs_wb(input iclass_t c);
        return (c == CL_ALU) || (c == CL_IMM) || (c == CL_LD);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_instr_decode.sv
// Combinational opcode decoder: maps IR[6:0] to the ALU function, the
// ALU operand source and the instruction class used by the sequencer.
module instr_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_alu_src,
    output iclass_t    o_iclass
);

    // Opcode lookup; anything not in the map is classed illegal with neutral fields
    always_comb begin
        o_alu_op  = ALU_ADD;
        o_alu_src = SRC_REG;
        o_iclass  = CL_ILL;
        case (i_opcode)
            OP_LD:  begin o_alu_op = ALU_ADD; o_alu_src = SRC_OFF; o_iclass = CL_LD;    end
            OP_ST:  begin o_alu_op = ALU_ADD; o_alu_src = SRC_OFF; o_iclass = CL_ST;    end
            OP_ADD: begin o_alu_op = ALU_ADD; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_SUB: begin o_alu_op = ALU_SUB; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_INV: begin o_alu_op = ALU_INV; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_LSL: begin o_alu_op = ALU_LSL; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_LSR: begin o_alu_op = ALU_LSR; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_AND: begin o_alu_op = ALU_AND; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_OR:  begin o_alu_op = ALU_OR;  o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            OP_SLT: begin o_alu_op = ALU_SLT; o_alu_src = SRC_REG; o_iclass = CL_ALU;   end
            // Branches compare two registers with a subtract
            OP_BEQ: begin o_alu_op = ALU_SUB; o_alu_src = SRC_REG; o_iclass = CL_BR_EQ; end
            OP_BNE: begin o_alu_op = ALU_SUB; o_alu_src = SRC_REG; o_iclass = CL_BR_NE; end
            OP_JMP: begin o_alu_op = ALU_ADD; o_alu_src = SRC_REG; o_iclass = CL_JMP;   end
            OP_LUI: begin o_alu_op = ALU_LUI; o_alu_src = SRC_IMM; o_iclass = CL_IMM;   end
            OP_LLI: begin o_alu_op = ALU_LLI; o_alu_src = SRC_IMM; o_iclass = CL_IMM;   end
            default: begin
                o_alu_op  = ALU_ADD;
                o_alu_src = SRC_REG;
                o_iclass  = CL_ILL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with a
// ready handshake, drives the datapath enables and traps illegal opcodes
// and stalled memory accesses into a sticky FAULT state.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_branch,
    output logic       pc_jump,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src,
    output logic       reg_write_en,
    output logic       mem_to_reg,
    output logic       retired,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_code
);

    // Counter only needs to reach MEM_TIMEOUT-1 before the fault fires
    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic            TRAP_ILL = (ILLEGAL_TRAP != 0);

    state_t           r_state;
    state_t           w_next;
    state_t           w_next_fetch;
    iclass_t          r_class;
    logic [3:0]       r_alu_op;
    logic [1:0]       r_alu_src;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_fault_code;

    logic [3:0]       w_dec_op;
    logic [1:0]       w_dec_src;
    iclass_t          w_dec_class;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_dec_illegal;

    instr_decode u_decode (
        .i_opcode  (opcode),
        .o_alu_op  (w_dec_op),
        .o_alu_src (w_dec_src),
        .o_iclass  (w_dec_class)
    );

    // run is only looked at when an instruction finishes
    assign w_next_fetch  = run ? ST_FETCH : ST_IDLE;
    assign w_dec_illegal = (w_dec_class == CL_ILL);

    // A memory access is stalled when a request is outstanding and not acknowledged
    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    // Ready on the last permitted cycle still completes the access
    assign w_timeout = w_waiting && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready)      w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_DECODE: begin
                if (w_dec_illegal) w_next = TRAP_ILL ? ST_FAULT : w_next_fetch;
                else               w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (r_class)
                    CL_ALU, CL_IMM: w_next = ST_WB;
                    CL_LD, CL_ST:   w_next = ST_MEM;
                    default:        w_next = w_next_fetch;
                endcase
            end
            ST_MEM: begin
                if (mem_ready)      w_next = (r_class == CL_LD) ? ST_WB : w_next_fetch;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_WB:    w_next = w_next_fetch;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Decoded fields are captured on leaving DECODE and held for the rest of the instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op  <= ALU_ADD;
            r_alu_src <= SRC_REG;
            r_class   <= CL_ALU;
        end else if (r_state == ST_DECODE) begin
            r_alu_op  <= w_dec_op;
            r_alu_src <= w_dec_src;
            r_class   <= w_dec_class;
        end
    end

    // Memory wait counter: restarts on every state change, counts stalled request cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fault cause, latched once on entry to FAULT and kept until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_code <= FLT_NONE;
        end else if ((w_next == ST_FAULT) && (r_state != ST_FAULT)) begin
            r_fault_code <= (r_state == ST_DECODE) ? FLT_ILLEGAL : FLT_TIMEOUT;
        end
    end

    // Output logic: enables decoded from the current state and held instruction class
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_branch    = 1'b0;
        pc_jump      = 1'b0;
        alu_op       = r_alu_op;
        alu_src      = r_alu_src;
        reg_write_en = 1'b0;
        mem_to_reg   = 1'b0;
        retired      = 1'b0;
        busy         = 1'b0;
        fault        = 1'b0;
        fault_code   = FLT_NONE;
        case (r_state)
            ST_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            ST_DECODE: begin
                busy    = 1'b1;
                // Without trapping, an illegal opcode retires as a NOP right here
                retired = w_dec_illegal && !TRAP_ILL;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                pc_branch = ((r_class == CL_BR_EQ) && zero) ||
                            ((r_class == CL_BR_NE) && !zero);
                pc_jump   = (r_class == CL_JMP);
                retired   = is_ctrl_xfer(r_class);
            end
            ST_MEM: begin
                busy         = 1'b1;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_class == CL_ST);
                mem_to_reg   = (r_class == CL_LD);
                retired      = (r_class == CL_ST) && mem_ready;
            end
            ST_WB: begin
                busy         = 1'b1;
                reg_write_en = needs_wb(r_class);
                retired      = 1'b1;
                mem_to_reg   = (r_class == CL_LD);
            end
            ST_FAULT: begin
                fault      = 1'b1;
                fault_code = r_fault_code;
                alu_op     = ALU_ADD;
                alu_src    = SRC_REG;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: two instances (illegal-opcode trap on and
// off) share one stimulus stream; a per-instruction reference model predicts
// every cycle's outputs from the instruction timing rules.
module tb_multicycle_sequencer;

    localparam int TO = 16;

    // Instruction kinds used by the reference model
    localparam int K_WB  = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BEQ = 3;
    localparam int K_BNE = 4;
    localparam int K_JMP = 5;
    localparam int K_ILL = 6;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       sel;
        logic       irl;
        logic       pci;
        logic       br;
        logic       jmp;
        logic [3:0] op;
        logic [1:0] src;
        logic       rwe;
        logic       m2r;
        logic       ret;
        logic       busy;
        logic       flt;
        logic [1:0] code;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;

    logic       mem_req_t, mem_we_t, mem_addr_sel_t, ir_load_t, pc_inc_t, pc_branch_t, pc_jump_t;
    logic [3:0] alu_op_t;
    logic [1:0] alu_src_t, fault_code_t;
    logic       reg_write_en_t, mem_to_reg_t, retired_t, busy_t, fault_t;

    logic       mem_req_n, mem_we_n, mem_addr_sel_n, ir_load_n, pc_inc_n, pc_branch_n, pc_jump_n;
    logic [3:0] alu_op_n;
    logic [1:0] alu_src_n, fault_code_n;
    logic       reg_write_en_n, mem_to_reg_n, retired_n, busy_n, fault_n;

    ov_t got_t, got_n;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .ILLEGAL_TRAP(1)) u_dut_trap (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr_sel(mem_addr_sel_t),
        .ir_load(ir_load_t), .pc_inc(pc_inc_t), .pc_branch(pc_branch_t), .pc_jump(pc_jump_t),
        .alu_op(alu_op_t), .alu_src(alu_src_t), .reg_write_en(reg_write_en_t),
        .mem_to_reg(mem_to_reg_t), .retired(retired_t), .busy(busy_t),
        .fault(fault_t), .fault_code(fault_code_t)
    );

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .ILLEGAL_TRAP(0)) u_dut_nop (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_n), .mem_we(mem_we_n), .mem_addr_sel(mem_addr_sel_n),
        .ir_load(ir_load_n), .pc_inc(pc_inc_n), .pc_branch(pc_branch_n), .pc_jump(pc_jump_n),
        .alu_op(alu_op_n), .alu_src(alu_src_n), .reg_write_en(reg_write_en_n),
        .mem_to_reg(mem_to_reg_n), .retired(retired_n), .busy(busy_n),
        .fault(fault_n), .fault_code(fault_code_n)
    );

    assign got_t = {mem_req_t, mem_we_t, mem_addr_sel_t, ir_load_t, pc_inc_t, pc_branch_t, pc_jump_t,
                    alu_op_t, alu_src_t, reg_write_en_t, mem_to_reg_t, retired_t, busy_t,
                    fault_t, fault_code_t};
    assign got_n = {mem_req_n, mem_we_n, mem_addr_sel_n, ir_load_n, pc_inc_n, pc_branch_n, pc_jump_n,
                    alu_op_n, alu_src_n, reg_write_en_n, mem_to_reg_n, retired_n, busy_n,
                    fault_n, fault_code_n};

    int n_total = 0;
    int n_bad   = 0;
    int icnt    = 0;

    // Reference model state, index 0 = trapping instance, 1 = NOP instance
    bit         m_idle;
    logic [3:0] m_op  [2];
    logic [1:0] m_src [2];
    bit         m_flt [2];
    logic [1:0] m_code[2];

    logic [6:0] legal [15] = '{7'b0000011, 7'b0000111, 7'b0001011, 7'b0001111, 7'b0010011,
                               7'b0010111, 7'b0011011, 7'b0011111, 7'b0100011, 7'b0100111,
                               7'b0101111, 7'b0110011, 7'b0110111, 7'b0111011, 7'b0111111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [6:0] op, output int kind,
                                    output logic [3:0] aop, output logic [1:0] asrc);
        kind = K_WB; aop = 4'd0; asrc = 2'd0;
        case (op)
            7'b0000011: begin kind = K_LD;  asrc = 2'b01; end
            7'b0000111: begin kind = K_ST;  asrc = 2'b01; end
            7'b0001011: aop = 4'd0;
            7'b0001111: aop = 4'd1;
            7'b0010011: aop = 4'd2;
            7'b0010111: aop = 4'd3;
            7'b0011011: aop = 4'd4;
            7'b0011111: aop = 4'd5;
            7'b0100011: aop = 4'd6;
            7'b0100111: aop = 4'd7;
            7'b0101111: begin kind = K_BEQ; aop = 4'd1; end
            7'b0110011: begin kind = K_BNE; aop = 4'd1; end
            7'b0110111: kind = K_JMP;
            7'b0111011: begin aop = 4'd8; asrc = 2'b10; end
            7'b0111111: begin aop = 4'd9; asrc = 2'b10; end
            default:    kind = K_ILL;
        endcase
    endfunction

    function automatic bit run_at(input int k, input int drop);
        return (drop < 0) || (k < drop);
    endfunction

    task automatic drv(input bit r, input bit rdy);
        run = r;
        mem_ready = rdy;
    endtask

    // Compare one cycle for both instances, then advance to the next negedge
    task automatic cyc(input string ph, input ov_t e, input bit ill_dec);
        ov_t x;
        #1;
        for (int d = 0; d < 2; d++) begin
            x = e;
            x.op  = m_op[d];
            x.src = m_src[d];
            if (ill_dec) x.ret = (d == 1);
            if (m_flt[d]) begin
                x = '0;
                x.flt  = 1'b1;
                x.code = m_code[d];
            end
            chk($sformatf("%s_%s_i%0d", ph, (d == 0) ? "trap" : "nop", icnt),
                {12'b0, ((d == 0) ? got_t : got_n)}, {12'b0, x});
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_op[d] = 4'd0; m_src[d] = 2'd0; m_flt[d] = 1'b0; m_code[d] = 2'd0;
        end
    endtask

    task automatic do_reset();
        drv(0, 0);
        rst_n = 1'b0;
        model_clear();
        cyc("reset", '0, 1'b0);
        cyc("reset", '0, 1'b0);
        rst_n = 1'b1;
        m_idle = 1'b1;
    endtask

    task automatic timeout_model();
        for (int d = 0; d < 2; d++)
            if (!m_flt[d]) begin m_flt[d] = 1'b1; m_code[d] = 2'b10; end
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 1'($urandom_range(0, 1)));
            cyc("idle", '0, 1'b0);
        end
    endtask

    task automatic do_hold(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc("hold", '0, 1'b0);
        end
    endtask

    // One instruction: fw/mw = wait cycles before mem_ready in FETCH/MEM,
    // drop = cycle index at which run falls (-1 never), rst_mem = MEM cycle to reset in (-1 never)
    task automatic do_instr(input logic [6:0] op, input bit z, input int fw, input int mw,
                            input int drop, input int rst_mem);
        int kind; logic [3:0] aop; logic [1:0] asrc;
        int k; ov_t e; bit rdy; bit done;
        icnt++;
        ref_dec(op, kind, aop, asrc);
        opcode = op;
        zero = z;
        if (m_idle) begin
            drv(1, 0);
            cyc("idle", '0, 1'b0);
            m_idle = 1'b0;
        end
        k = 0;
        done = 1'b0;
        for (int i = 0; i < TO; i++) begin
            rdy = (i == fw);
            drv(run_at(k, drop), rdy);
            e = '0; e.req = 1; e.busy = 1; e.irl = rdy; e.pci = rdy;
            cyc("fetch", e, 1'b0);
            k++;
            if (rdy) begin done = 1'b1; break; end
        end
        if (!done) begin timeout_model(); return; end

        drv(run_at(k, drop), 0);
        e = '0; e.busy = 1;
        cyc("decode", e, kind == K_ILL);
        k++;
        if (kind == K_ILL) begin
            for (int d = 0; d < 2; d++) begin m_op[d] = 4'd0; m_src[d] = 2'd0; end
            if (!m_flt[0]) begin m_flt[0] = 1'b1; m_code[0] = 2'b01; end
            m_idle = !run;
            return;
        end
        for (int d = 0; d < 2; d++) begin m_op[d] = aop; m_src[d] = asrc; end

        drv(run_at(k, drop), 0);
        e = '0; e.busy = 1;
        e.br  = ((kind == K_BEQ) && z) || ((kind == K_BNE) && !z);
        e.jmp = (kind == K_JMP);
        e.ret = (kind == K_BEQ) || (kind == K_BNE) || (kind == K_JMP);
        cyc("exec", e, 1'b0);
        k++;
        if (e.ret) begin m_idle = !run; return; end

        if ((kind == K_LD) || (kind == K_ST)) begin
            done = 1'b0;
            for (int i = 0; i < TO; i++) begin
                rdy = (i == mw);
                drv(run_at(k, drop), rdy);
                if (i == rst_mem) begin
                    #1;
                    rst_n = 1'b0;
                    run = 1'b0;
                    model_clear();
                    cyc("rstmid", '0, 1'b0);
                    cyc("rstmid", '0, 1'b0);
                    rst_n = 1'b1;
                    m_idle = 1'b1;
                    return;
                end
                e = '0; e.busy = 1; e.req = 1; e.sel = 1;
                e.we  = (kind == K_ST);
                e.m2r = (kind == K_LD);
                e.ret = (kind == K_ST) && rdy;
                cyc("mem", e, 1'b0);
                k++;
                if (rdy) begin done = 1'b1; break; end
            end
            if (!done) begin timeout_model(); return; end
            if (kind == K_ST) begin m_idle = !run; return; end
        end

        drv(run_at(k, drop), 0);
        e = '0; e.busy = 1; e.rwe = 1; e.ret = 1; e.m2r = (kind == K_LD);
        cyc("wb", e, 1'b0);
        m_idle = !run;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    logic [6:0] r_op;
    int         r_fw, r_mw, r_drop;

    initial begin
        model_clear();
        m_idle = 1'b1;
        @(negedge clk);
        do_reset();

        // Directed: latency, classes, memory waits
        do_instr(7'b0001011, 0, 0, 0, -1, -1);   // ADD from idle
        do_instr(7'b0001011, 0, 0, 0, -1, -1);   // ADD back-to-back
        do_instr(7'b0000011, 0, 0, 3, -1, -1);   // LD, 3 MEM waits
        do_instr(7'b0101111, 1, 0, 0, -1, -1);   // BEQ taken
        do_instr(7'b0110011, 1, 0, 0, -1, -1);   // BNE not taken
        do_instr(7'b0101111, 0, 0, 0, -1, -1);   // BEQ not taken
        do_instr(7'b0110011, 0, 0, 0, -1, -1);   // BNE taken
        do_instr(7'b0110111, 0, 1, 0, -1, -1);   // JMP
        do_instr(7'b0111011, 0, 0, 0, -1, -1);   // LUI
        do_instr(7'b0111111, 0, 2, 0, -1, -1);   // LLI
        do_instr(7'b0000111, 0, 0, 1, -1, -1);   // ST
        do_instr(7'b0000111, 0, 0, 3, 4, -1);    // ST, run dropped during MEM wait
        do_idle(3);
        do_instr(7'b0001111, 0, TO - 1, 0, -1, -1);  // ready on last fetch cycle
        do_instr(7'b0000011, 0, 0, TO - 1, -1, -1);  // ready on last MEM cycle
        // Illegal opcode: trap instance faults, NOP instance carries on
        do_instr(7'b1111111, 0, 0, 0, -1, -1);
        do_instr(7'b0100011, 0, 0, 0, -1, -1);
        do_instr(7'b0000111, 0, 1, 1, -1, -1);
        do_reset();
        // Fetch and MEM timeouts
        do_instr(7'b0001011, 0, TO, 0, -1, -1);
        do_hold(3);
        do_reset();
        do_instr(7'b0000011, 0, 0, TO, -1, -1);
        do_hold(3);
        do_reset();
        // Reset in the middle of a store's memory wait
        do_instr(7'b0000111, 0, 0, 5, -1, 2);
        do_instr(7'b0001011, 0, 0, 0, -1, -1);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            if (m_flt[0] && ($urandom_range(0, 3) == 0)) do_reset();
            r_op   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal[$urandom_range(0, 14)];
            r_fw   = ($urandom_range(0, 19) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            r_mw   = ($urandom_range(0, 19) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            r_drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_instr(r_op, 1'($urandom_range(0, 1)), r_fw, r_mw, r_drop, -1);
            if (m_idle) do_idle(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
